fetch_ctrl: RTL and testbench

//  Sequencer for the fetch stage. Generates pc_en, flush, jump_en and pc_jump_addr.

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_ctrl_mispred.sv | 40 ++++
 rtl/fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared definitions for the fetch-stage sequencer: FSM state
//               encoding, counter width and default boot/flush lengths.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Wide enough for the 1..15 range of both cycle parameters.
  localparam int CNT_W = 4;

  localparam int BOOT_CYCLES_DEFAULT  = 3;
  localparam int FLUSH_CYCLES_DEFAULT = 2;

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_mispred.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_mispred
// Description : Combinational branch mispredict detection and redirect
//               address selection. Also used by the BTB update path.
// Ports       : branch_valid   in  1   resolved branch/jump in EX
//               branch_taken   in  1   actual direction
//               pred_taken     in  1   predicted direction
//               pred_target    in  32  predicted target
//               branch_target  in  32  computed target
//               pc_plus4       in  32  fall-through address
//               mispred        out 1   prediction was wrong
//               redirect_addr  out 32  correct next PC
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl_mispred
  import fetch_ctrl_pkg::*;
(
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc_plus4,
  output logic        mispred,
  output logic [31:0] redirect_addr
);

  logic dir_wrong;
  logic tgt_wrong;

  assign dir_wrong = (branch_taken != pred_taken);
  // A target mismatch only matters when the branch actually went that way.
  assign tgt_wrong = branch_taken && (branch_target != pred_target);

  assign mispred       = branch_valid && (dir_wrong || tgt_wrong);
  assign redirect_addr = branch_taken ? branch_target : pc_plus4;

endmodule : fetch_ctrl_mispred
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch-stage sequencer. Holds fetch after reset for a boot
//               window, redirects the PC on mispredicts and stretches the
//               flush across the pipeline bubbles. Stalls on M-unit busy and
//               load-use hazards.
// Ports       : clk, rst (async, active-high)
//               load_use_hazard, mdu_busy          stall requests
//               ex_branch_valid/taken, ex_pred_taken,
//               ex_pred_target, ex_branch_target,
//               ex_pc_plus4                        EX branch resolution
//               pc_en, flush, jump_en, pc_jump_addr fetch controls
//               perf_redirect_cnt, perf_stall_cnt  (FETCH_CTRL_PERF_EN only)
// Macros      : FETCH_CTRL_PERF_EN - adds saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES  = BOOT_CYCLES_DEFAULT,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_hazard,
  input  logic        mdu_busy,
  input  logic        ex_branch_valid,
  input  logic        ex_branch_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic [31:0] ex_branch_target,
  input  logic [31:0] ex_pc_plus4,
  output logic        pc_en,
  output logic        flush,
  output logic        jump_en,
  output logic [31:0] pc_jump_addr
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] BOOT_LOAD  = CNT_W'(BOOT_CYCLES - 1);
  // The redirect cycle itself is the first flush cycle, so FLUSH covers
  // FLUSH_CYCLES-1 cycles and the counter is loaded one lower still.
  localparam logic [CNT_W-1:0] FLUSH_LOAD =
      CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
  localparam bit               FLUSH_MULTI = (FLUSH_CYCLES > 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      last_addr;

  logic             mispred;
  logic [31:0]      redirect_addr;

  fetch_ctrl_mispred u_mispred (
    .branch_valid  (ex_branch_valid),
    .branch_taken  (ex_branch_taken),
    .pred_taken    (ex_pred_taken),
    .pred_target   (ex_pred_target),
    .branch_target (ex_branch_target),
    .pc_plus4      (ex_pc_plus4),
    .mispred       (mispred),
    .redirect_addr (redirect_addr)
  );

  // Outputs react in the same cycle as the EX resolution, so they are
  // decoded from the current state and inputs rather than registered.
  always_comb begin
    pc_en   = 1'b0;
    flush   = 1'b0;
    jump_en = 1'b0;
    case (state)
      ST_BOOT: begin
        flush = 1'b1;
      end
      ST_RUN: begin
        if (mispred) begin
          pc_en   = 1'b1;
          flush   = 1'b1;
          jump_en = 1'b1;
        end else if (!(mdu_busy || load_use_hazard)) begin
          pc_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        pc_en = 1'b1;
        flush = 1'b1;
      end
      default: begin
        flush = 1'b1;
      end
    endcase
  end

  // Between redirects the address output shows the last redirect target.
  assign pc_jump_addr = jump_en ? redirect_addr : last_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BOOT;
      cnt       <= BOOT_LOAD;
      last_addr <= 32'd0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (cnt == '0) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (mispred) begin
            last_addr <= redirect_addr;
            if (FLUSH_MULTI) begin
              cnt   <= FLUSH_LOAD;
              state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_BOOT;
          cnt   <= BOOT_LOAD;
        end
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic stall_evt;
  assign stall_evt = (state == ST_RUN) && !pc_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirect_cnt <= 32'd0;
      perf_stall_cnt    <= 32'd0;
    end else begin
      if (jump_en && (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end
      if (stall_evt && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl (default parameters).
//               Each row drives one cycle of inputs and queues the expected
//               outputs; the row's task pops and compares them mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        load_use_hazard;
  logic        mdu_busy;
  logic        ex_branch_valid;
  logic        ex_branch_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] ex_branch_target;
  logic [31:0] ex_pc_plus4;
  logic        pc_en;
  logic        flush;
  logic        jump_en;
  logic [31:0] pc_jump_addr;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_redirect_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .load_use_hazard  (load_use_hazard),
    .mdu_busy         (mdu_busy),
    .ex_branch_valid  (ex_branch_valid),
    .ex_branch_taken  (ex_branch_taken),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_branch_target (ex_branch_target),
    .ex_pc_plus4      (ex_pc_plus4),
    .pc_en            (pc_en),
    .flush            (flush),
    .jump_en          (jump_en),
    .pc_jump_addr     (pc_jump_addr)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_redirect_cnt(perf_redirect_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic        t;
    logic        pt;
    logic [31:0] tgt;
    logic [31:0] ptgt;
    logic [31:0] p4;
    logic        mdu;
    logic        luh;
    logic        epc;
    logic        efl;
    logic        ej;
    logic [31:0] ea;
  } row_t;

  typedef struct {
    logic        epc;
    logic        efl;
    logic        ej;
    logic [31:0] ea;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic row_t mk(input logic r, input logic v, input logic t,
                              input logic pt, input logic [31:0] tgt,
                              input logic [31:0] ptgt, input logic [31:0] p4,
                              input logic mdu, input logic luh,
                              input logic epc, input logic efl, input logic ej,
                              input logic [31:0] ea);
    row_t x;
    x.rst = r;   x.v = v;     x.t = t;   x.pt = pt;
    x.tgt = tgt; x.ptgt = ptgt; x.p4 = p4;
    x.mdu = mdu; x.luh = luh;
    x.epc = epc; x.efl = efl; x.ej = ej; x.ea = ea;
    return x;
  endfunction

  // Drives one cycle at the falling edge and queues what the outputs must be.
  task automatic apply(input row_t r);
    exp_t e;
    @(negedge clk);
    rst              = r.rst;
    ex_branch_valid  = r.v;
    ex_branch_taken  = r.t;
    ex_pred_taken    = r.pt;
    ex_branch_target = r.tgt;
    ex_pred_target   = r.ptgt;
    ex_pc_plus4      = r.p4;
    mdu_busy         = r.mdu;
    load_use_hazard  = r.luh;
    e.epc = r.epc; e.efl = r.efl; e.ej = r.ej; e.ea = r.ea;
    sb.push_back(e);
  endtask

  // 1: reset values, inputs ignored during reset and boot, RUN at cycle 3.
  task automatic test_reset();
    row_t rows[6];
    exp_t e;
    rows[0] = mk(1, 1,1,0, 32'h100,32'h0,32'h4, 1,1, 0,1,0, 32'h0);
    rows[1] = mk(1, 1,0,1, 32'h100,32'h0,32'h4, 0,0, 0,1,0, 32'h0);
    rows[2] = mk(0, 1,1,0, 32'h100,32'h0,32'h4, 0,0, 0,1,0, 32'h0);
    rows[3] = mk(0, 1,0,1, 32'h100,32'h0,32'h8, 1,0, 0,1,0, 32'h0);
    rows[4] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0, 0,1, 0,1,0, 32'h0);
    rows[5] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0, 0,0, 1,0,0, 32'h0);
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
        errors++;
        $display("FAIL reset[%0d]: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
                 i, pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
      end
    end
  endtask

  // 2: taken but predicted not-taken; FLUSH ignores a second mispredict;
  //    back-to-back redirect right after returning to RUN.
  task automatic test_mispred_taken();
    row_t rows[6];
    exp_t e;
    rows[0] = mk(0, 1,1,0, 32'h100,32'h0,  32'h10, 0,0, 1,1,1, 32'h100);
    rows[1] = mk(0, 1,1,0, 32'h999,32'h0,  32'h14, 1,1, 1,1,0, 32'h100);
    rows[2] = mk(0, 0,0,0, 32'h0,  32'h0,  32'h0,  0,0, 1,0,0, 32'h100);
    rows[3] = mk(0, 1,1,0, 32'h120,32'h0,  32'h24, 0,0, 1,1,1, 32'h120);
    rows[4] = mk(0, 0,0,0, 32'h0,  32'h0,  32'h0,  0,0, 1,1,0, 32'h120);
    rows[5] = mk(0, 0,0,0, 32'h0,  32'h0,  32'h0,  0,0, 1,0,0, 32'h120);
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
        errors++;
        $display("FAIL mispred_taken[%0d]: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
                 i, pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
      end
    end
  endtask

  // 3: not taken but predicted taken -> fall-through address.
  task automatic test_mispred_not_taken();
    row_t rows[3];
    exp_t e;
    rows[0] = mk(0, 1,0,1, 32'h500,32'h500,32'h44, 0,0, 1,1,1, 32'h44);
    rows[1] = mk(0, 0,0,0, 32'h0,  32'h0,  32'h0,  0,0, 1,1,0, 32'h44);
    rows[2] = mk(0, 0,0,0, 32'h0,  32'h0,  32'h0,  0,0, 1,0,0, 32'h44);
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
        errors++;
        $display("FAIL mispred_not_taken[%0d]: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
                 i, pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
      end
    end
  endtask

  // 4: right direction, wrong target.
  task automatic test_target_mismatch();
    row_t rows[3];
    exp_t e;
    rows[0] = mk(0, 1,1,1, 32'h200,32'h204,32'h48, 0,0, 1,1,1, 32'h200);
    rows[1] = mk(0, 0,0,0, 32'h0,  32'h0,  32'h0,  0,0, 1,1,0, 32'h200);
    rows[2] = mk(0, 0,0,0, 32'h0,  32'h0,  32'h0,  0,0, 1,0,0, 32'h200);
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
        errors++;
        $display("FAIL target_mismatch[%0d]: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
                 i, pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
      end
    end
  endtask

  // 5: correct predictions and invalid slots cause no action.
  task automatic test_correct_pred();
    row_t rows[4];
    exp_t e;
    rows[0] = mk(0, 1,1,1, 32'h80, 32'h80, 32'h4C, 0,0, 1,0,0, 32'h200);
    rows[1] = mk(0, 1,0,0, 32'h300,32'h400,32'h50, 0,0, 1,0,0, 32'h200);
    rows[2] = mk(0, 0,1,0, 32'h600,32'h0,  32'h54, 0,0, 1,0,0, 32'h200);
    rows[3] = mk(0, 0,0,0, 32'h0,  32'h0,  32'h0,  0,0, 1,0,0, 32'h200);
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
        errors++;
        $display("FAIL correct_pred[%0d]: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
                 i, pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
      end
    end
  endtask

  // 6: mdu_busy for 4 cycles, mispredict in cycle 2 wins; FLUSH ignores busy.
  task automatic test_mdu_busy();
    row_t rows[5];
    exp_t e;
    rows[0] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  1,0, 0,0,0, 32'h200);
    rows[1] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  1,1, 0,0,0, 32'h200);
    rows[2] = mk(0, 1,1,0, 32'h300,32'h0,32'h60, 1,1, 1,1,1, 32'h300);
    rows[3] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  1,1, 1,1,0, 32'h300);
    rows[4] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  0,0, 1,0,0, 32'h300);
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
        errors++;
        $display("FAIL mdu_busy[%0d]: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
                 i, pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
      end
    end
  endtask

  // 7: fresh reset, one-cycle load-use stall, then one redirect.
  task automatic test_load_use();
    row_t rows[9];
    exp_t e;
    rows[0] = mk(1, 0,0,0, 32'h0,  32'h0,32'h0,  0,0, 0,1,0, 32'h0);
    rows[1] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  0,1, 0,1,0, 32'h0);
    rows[2] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  0,0, 0,1,0, 32'h0);
    rows[3] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  0,0, 0,1,0, 32'h0);
    rows[4] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  0,1, 0,0,0, 32'h0);
    rows[5] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  0,0, 1,0,0, 32'h0);
    rows[6] = mk(0, 1,0,1, 32'h700,32'h0,32'h70, 0,0, 1,1,1, 32'h70);
    rows[7] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  0,1, 1,1,0, 32'h70);
    rows[8] = mk(0, 0,0,0, 32'h0,  32'h0,32'h0,  0,0, 1,0,0, 32'h70);
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
        errors++;
        $display("FAIL load_use[%0d]: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
                 i, pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
      end
`ifdef FETCH_CTRL_PERF_EN
      if (i == 5) begin
        checks++;
        if (perf_stall_cnt !== 32'd1 || perf_redirect_cnt !== 32'd0) begin
          errors++;
          $display("FAIL perf_after_stall: got stall=%0d redirect=%0d, want stall=1 redirect=0",
                   perf_stall_cnt, perf_redirect_cnt);
        end
      end
      if (i == 8) begin
        checks++;
        if (perf_stall_cnt !== 32'd1 || perf_redirect_cnt !== 32'd1) begin
          errors++;
          $display("FAIL perf_after_redirect: got stall=%0d redirect=%0d, want stall=1 redirect=1",
                   perf_stall_cnt, perf_redirect_cnt);
        end
      end
`endif
    end
  endtask

  // 8: asynchronous reset in the middle of FLUSH, then the boot repeats.
  task automatic test_reset_mid_flush();
    row_t rows[5];
    exp_t e;
    apply(mk(0, 1,1,0, 32'h40,32'h0,32'h30, 0,0, 1,1,1, 32'h40));
    #2;
    e = sb.pop_front();
    checks++;
    if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
      errors++;
      $display("FAIL rst_flush_redirect: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
               pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
    end
    apply(mk(0, 0,0,0, 32'h0,32'h0,32'h0, 0,0, 1,1,0, 32'h40));
    #2;
    e = sb.pop_front();
    checks++;
    if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
      errors++;
      $display("FAIL rst_flush_inflush: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
               pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
    end
    // Assert reset between clock edges; outputs must change before any edge.
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({pc_en, flush, jump_en} !== 3'b010 || pc_jump_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_flush_async: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=0 flush=1 jump_en=0 addr=00000000",
               pc_en, flush, jump_en, pc_jump_addr);
    end
    rows[0] = mk(1, 0,0,0, 32'h0,32'h0,32'h0, 0,0, 0,1,0, 32'h0);
    rows[1] = mk(0, 1,1,0, 32'h90,32'h0,32'h0, 0,0, 0,1,0, 32'h0);
    rows[2] = mk(0, 0,0,0, 32'h0,32'h0,32'h0, 1,0, 0,1,0, 32'h0);
    rows[3] = mk(0, 0,0,0, 32'h0,32'h0,32'h0, 0,0, 0,1,0, 32'h0);
    rows[4] = mk(0, 0,0,0, 32'h0,32'h0,32'h0, 0,0, 1,0,0, 32'h0);
    foreach (rows[i]) begin
      apply(rows[i]);
      #2;
      e = sb.pop_front();
      checks++;
      if ({pc_en, flush, jump_en} !== {e.epc, e.efl, e.ej} || pc_jump_addr !== e.ea) begin
        errors++;
        $display("FAIL rst_flush_reboot[%0d]: got pc_en=%b flush=%b jump_en=%b addr=%h, want pc_en=%b flush=%b jump_en=%b addr=%h",
                 i, pc_en, flush, jump_en, pc_jump_addr, e.epc, e.efl, e.ej, e.ea);
      end
    end
`ifdef FETCH_CTRL_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_redirect_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_after_reset: got stall=%0d redirect=%0d, want 0 0",
               perf_stall_cnt, perf_redirect_cnt);
    end
`endif
  endtask

  initial begin
    rst              = 1'b1;
    load_use_hazard  = 1'b0;
    mdu_busy         = 1'b0;
    ex_branch_valid  = 1'b0;
    ex_branch_taken  = 1'b0;
    ex_pred_taken    = 1'b0;
    ex_pred_target   = 32'h0;
    ex_branch_target = 32'h0;
    ex_pc_plus4      = 32'h0;

    test_reset();
    test_mispred_taken();
    test_mispred_not_taken();
    test_target_mismatch();
    test_correct_pred();
    test_mdu_busy();
    test_load_use();
    test_reset_mid_flush();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_ctrl
`default_nettype wire
